// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-signal decode, operand forwarding and stall/flush control.
// ALU operands and store data are combinational from the registered fields plus forwarding.
module id_ex_stage #(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_result,
    output logic          ex_valid,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_signal,
    output logic [W-1:0]  ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic [RW-1:0] ex_rt,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_illegal
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm;
        logic          alu_src;
        logic [2:0]    signal;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          illegal;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, load;
    logic [2:0] dec_signal;
    logic       dec_illegal;
    logic [W-1:0] fwd_rs, fwd_rt;

    always_comb begin
        dec_signal  = 3'b010;
        dec_illegal = 1'b0;
        unique case (id_alu_op)
            2'b01: dec_signal = 3'b110;
            2'b10: begin
                unique case (id_funct)
                    6'b100000: dec_signal = 3'b010;
                    6'b100010: dec_signal = 3'b110;
                    6'b100100: dec_signal = 3'b000;
                    6'b100101: dec_signal = 3'b001;
                    6'b101010: dec_signal = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_signal = 3'b010;
        endcase
    end

    always_comb begin
        load.valid      = id_valid;
        load.rs         = id_rs;
        load.rt         = id_rt;
        load.dest       = id_reg_dst ? id_rd : id_rt;
        load.rs_data    = id_rs_data;
        load.rt_data    = id_rt_data;
        load.imm        = id_imm;
        load.alu_src    = id_alu_src;
        load.signal     = dec_signal;
        // An unsupported R-type must never commit a register write.
        load.reg_write  = id_reg_write & ~dec_illegal;
        load.mem_read   = id_mem_read;
        load.mem_write  = id_mem_write;
        load.mem_to_reg = id_mem_to_reg;
        load.illegal    = dec_illegal;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d = load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs) begin
            fwd_rs = memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rt) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rt) begin
            fwd_rt = memwb_result;
        end
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_valid      = ex_q.valid;
    assign alu_signal    = ex_q.signal;
    assign ex_dest       = ex_q.dest;
    assign ex_rt         = ex_q.rt;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, decode, forwarding, stall/flush, stores.
module tb_id_ex_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned RW = 5;

    logic          clk;
    logic          rst, stall, flush;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
    logic          id_mem_to_reg;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [W-1:0]  exmem_result, memwb_result;
    logic          ex_valid;
    logic [W-1:0]  alu_a, alu_b, ex_store_data;
    logic [2:0]    alu_signal;
    logic [RW-1:0] ex_dest, ex_rt;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    id_ex_stage #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_rt(ex_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_alu_op = 2'b00; id_funct = '0; id_alu_src = 1'b0; id_reg_dst = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        id_valid = 1'b1; id_rd = 5'd7; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        id_rs_data = 32'h1111; id_rt_data = 32'h2222; id_alu_op = 2'b01; id_mem_read = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b want 0", ex_valid);
        end
        tests_run++;
        if (alu_signal !== 3'b000) begin
            tests_failed++; $display("FAIL reset_signal: got %b want 000", alu_signal);
        end
        tests_run++;
        if ({ex_dest, ex_rt} !== '0) begin
            tests_failed++; $display("FAIL reset_dest_rt: got %h/%h want 0/0", ex_dest, ex_rt);
        end
        tests_run++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal});
        end
        tests_run++;
        if (alu_a !== '0 || alu_b !== '0 || ex_store_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h/%h want 0/0/0", alu_a, alu_b, ex_store_data);
        end
    endtask

    task automatic test_rtype_slt();
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7;
        id_rs_data = 32'd5; id_rt_data = 32'd9; id_alu_op = 2'b10; id_funct = 6'b101010;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
        tick();
        tests_run++;
        if (alu_a !== 32'd5 || alu_b !== 32'd9) begin
            tests_failed++; $display("FAIL slt_operands: got %h/%h want 5/9", alu_a, alu_b);
        end
        tests_run++;
        if (alu_signal !== 3'b111) begin
            tests_failed++; $display("FAIL slt_signal: got %b want 111", alu_signal);
        end
        tests_run++;
        if (ex_dest !== 5'd7 || ex_rt !== 5'd2) begin
            tests_failed++; $display("FAIL slt_dest: got %0d/%0d want 7/2", ex_dest, ex_rt);
        end
        tests_run++;
        if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL slt_ctrl: got v%b rw%b il%b want v1 rw1 il0",
                     ex_valid, ex_reg_write, ex_illegal);
        end
    endtask

    task automatic test_decode();
        logic [1:0] op;
        logic [5:0] fn;
        logic [2:0] exp;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin op = 2'b00; fn = 6'b000011; exp = 3'b010; end
                1: begin op = 2'b01; fn = 6'b100000; exp = 3'b110; end
                2: begin op = 2'b11; fn = 6'b100100; exp = 3'b010; end
                3: begin op = 2'b10; fn = 6'b100000; exp = 3'b010; end
                4: begin op = 2'b10; fn = 6'b100010; exp = 3'b110; end
                5: begin op = 2'b10; fn = 6'b100100; exp = 3'b000; end
                6: begin op = 2'b10; fn = 6'b100101; exp = 3'b001; end
                default: begin op = 2'b10; fn = 6'b101010; exp = 3'b111; end
            endcase
            clear_inputs();
            id_valid = 1'b1; id_alu_op = op; id_funct = fn; id_reg_write = 1'b1;
            id_rt = 5'd4; id_rd = 5'd9; id_reg_dst = 1'b0;
            id_mem_read = i[0]; id_mem_to_reg = i[1];
            tick();
            tests_run++;
            if (alu_signal !== exp || ex_illegal !== 1'b0 || ex_reg_write !== 1'b1) begin
                tests_failed++;
                $display("FAIL decode_%0d: got sig %b il %b rw %b want sig %b il 0 rw 1",
                         i, alu_signal, ex_illegal, ex_reg_write, exp);
            end
            tests_run++;
            if (ex_dest !== 5'd4 || ex_mem_read !== i[0] || ex_mem_to_reg !== i[1]) begin
                tests_failed++;
                $display("FAIL decode_ctrl_%0d: got dest %0d mr %b m2r %b want 4 %b %b",
                         i, ex_dest, ex_mem_read, ex_mem_to_reg, i[0], i[1]);
            end
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4;
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_reg_write = 1'b1;
        tick();
        id_valid = 1'b0; stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #1;
        tests_run++;
        if (alu_a !== 32'hAA) begin
            tests_failed++; $display("FAIL fwd_exmem_wins: got %h want aa", alu_a);
        end
        tests_run++;
        if (alu_b !== 32'h22) begin
            tests_failed++; $display("FAIL fwd_rt_untouched: got %h want 22", alu_b);
        end
        exmem_rd = 5'd0;
        #1;
        tests_run++;
        if (alu_a !== 32'hBB) begin
            tests_failed++; $display("FAIL fwd_exmem_rd0: got %h want bb", alu_a);
        end
        exmem_rd = 5'd3; exmem_reg_write = 1'b0;
        #1;
        tests_run++;
        if (alu_a !== 32'hBB) begin
            tests_failed++; $display("FAIL fwd_exmem_nowrite: got %h want bb", alu_a);
        end
        memwb_rd = 5'd4;
        #1;
        tests_run++;
        if (alu_a !== 32'h11 || alu_b !== 32'hBB || ex_store_data !== 32'hBB) begin
            tests_failed++;
            $display("FAIL fwd_memwb_rt: got %h/%h/%h want 11/bb/bb", alu_a, alu_b, ex_store_data);
        end
        stall = 1'b0;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_rs_data = 32'h100; id_rt_data = 32'h200; id_alu_op = 2'b01;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
        tick();
        stall = 1'b1;
        id_valid = 1'b0; id_rs_data = 32'hDEAD; id_rt_data = 32'hBEEF; id_rd = 5'd9;
        id_alu_op = 2'b10; id_funct = 6'b100100; id_reg_write = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if (alu_a !== 32'h100 || alu_b !== 32'h200 || alu_signal !== 3'b110 ||
                ex_dest !== 5'd3 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: got a%h b%h s%b d%0d v%b rw%b want 100 200 110 3 1 1",
                         c, alu_a, alu_b, alu_signal, ex_dest, ex_valid, ex_reg_write);
            end
        end
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h77;
        #1;
        tests_run++;
        if (alu_a !== 32'h77) begin
            tests_failed++; $display("FAIL stall_forward: got %h want 77", alu_a);
        end
        flush = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1;
        tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_signal !== 3'b000 ||
            ex_dest !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_with_stall: got v%b rw%b s%b d%0d want 0 0 000 0",
                     ex_valid, ex_reg_write, alu_signal, ex_dest);
        end
        clear_inputs();
    endtask

    task automatic test_illegal_and_store();
        clear_inputs();
        id_valid = 1'b1; id_alu_op = 2'b10; id_funct = 6'b000011; id_reg_write = 1'b1;
        id_rd = 5'd5; id_reg_dst = 1'b1;
        tick();
        tests_run++;
        if (alu_signal !== 3'b010 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_funct: got s%b il%b rw%b want 010 1 0",
                     alu_signal, ex_illegal, ex_reg_write);
        end
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd8; id_rt = 5'd6; id_rd = 5'd12;
        id_rs_data = 32'h1000; id_rt_data = 32'h99; id_imm = 32'hFFFF_FFFC;
        id_alu_src = 1'b1; id_mem_write = 1'b1;
        tick();
        memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h1234;
        #1;
        tests_run++;
        if (alu_b !== 32'hFFFF_FFFC || ex_store_data !== 32'h1234 || alu_a !== 32'h1000) begin
            tests_failed++;
            $display("FAIL store_operands: got a%h b%h sd%h want 1000 fffffffc 1234",
                     alu_a, alu_b, ex_store_data);
        end
        tests_run++;
        if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_dest !== 5'd6 ||
            ex_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_ctrl: got mw%b rw%b d%0d il%b want 1 0 6 0",
                     ex_mem_write, ex_reg_write, ex_dest, ex_illegal);
        end
    endtask

    task automatic test_flush_only();
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd2; id_rs_data = 32'h55; id_reg_write = 1'b1;
        id_mem_to_reg = 1'b1; flush = 1'b1;
        tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_to_reg !== 1'b0 ||
            alu_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_only: got v%b rw%b m2r%b a%h want 0 0 0 0",
                     ex_valid, ex_reg_write, ex_mem_to_reg, alu_a);
        end
        flush = 1'b0;
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || alu_a !== 32'h55 || ex_mem_to_reg !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_after_flush: got v%b a%h m2r%b want 1 55 1",
                     ex_valid, alu_a, ex_mem_to_reg);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_slt();
        test_decode();
        test_forward();
        test_stall_flush();
        test_illegal_and_store();
        test_flush_only();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
